// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge and its timeout counter.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH     = 16;
    localparam int unsigned APB_BUS_WIDTH      = 16;
    localparam int unsigned APB_STRB_WIDTH     = APB_BUS_WIDTH / 8;
    localparam int unsigned APB_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_BUS_WIDTH-1:0]  wdata;
        logic [APB_STRB_WIDTH-1:0] strb;
    } apb_cmd_t;

    // Read transfers never carry byte strobes onto the bus.
    function automatic logic [APB_STRB_WIDTH-1:0] bus_strb(input apb_cmd_t cmd);
        return cmd.write ? cmd.strb : '0;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter with expiry flag; only instantiated when
// APB_MASTER_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
    parameter int unsigned LIMIT = 64,
    localparam int unsigned CW   = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = (cnt_q == CW'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB4 master bridge, single outstanding transfer, all bus
// outputs registered. Optional ACCESS timeout enabled by APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel high, penable low, one cycle
// ACCESS | psel and penable high until pready (or timeout)
// RESP   | rsp_valid high until rsp_ready
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned BUS_WIDTH      = APB_BUS_WIDTH,
    parameter int unsigned STRB_WIDTH     = BUS_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [STRB_WIDTH-1:0] cmd_strb_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,

    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i,

    output logic                  busy_o
);

    apb_state_e            state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [BUS_WIDTH-1:0]  pwdata_q,    pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q,     pstrb_d;
    logic                  busy_q,      busy_d;

    logic cmd_accept;
    logic bus_done;

    assign cmd_accept = (state_q == IDLE) && cmd_valid_i && cmd_ready_q;
    assign bus_done   = (state_q == ACCESS) && psel_q && penable_q && pready_i;

`ifdef APB_MASTER_TIMEOUT_EN
    logic tmo_inc;
    logic tmo_expired;

    assign tmo_inc = (state_q == ACCESS) && !pready_i;

    apb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cmd_accept),
        .inc_i    (tmo_inc),
        .expired_o(tmo_expired)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write_i;
                    paddr_d     = cmd_addr_i;
                    pwdata_d    = cmd_wdata_i;
                    pstrb_d     = cmd_write_i ? cmd_strb_i : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // Normal completion takes priority over a timeout in the same cycle.
                if (bus_done) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_i;
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (tmo_expired) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
    assign busy_o      = busy_q;

endmodule
